// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives
// the hold/clear controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
// registers and the PC hold. It resolves four kinds of event:
//   - load-use stalls (a load in EX feeds the instruction in ID)
//   - mult/div interlock (an HI/LO op in ID while the mult/div unit is busy)
//   - control flushes (taken branch resolved in EX, jump resolved in ID)
//   - memory-wait freezes (the whole pipeline stops)
// It also tracks how long the multi-cycle mult/div unit stays busy and keeps
// a saturating count of the cycles in which the PC was held.
//
// Parameters
//   MD_LAT  cycles the mult/div unit is busy after an accepted start (>= 2)
//   CNT_W   width of the stall-cycle performance counter
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   id_rs/id_rt   source register fields of the instruction in ID
//   id_uses_rt    ID instruction actually reads rt
//   id_md_op      ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//   id_jump       ID instruction is j/jal/jr
//   ex_mem_read   EX instruction is a load
//   ex_wr_reg     destination register of the EX instruction
//   ex_br_taken   branch in EX resolved taken
//   ex_md_start   EX instruction starts the mult/div unit
//   mem_wait      instruction or data memory not ready
//   pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
//   exmem_hold, memwb_hold      pipeline register controls
//   md_busy       mult/div unit busy
//   stall_cycles  saturating count of cycles with pc_hold=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_op,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wr_reg,
  input  logic             ex_br_taken,
  input  logic             ex_md_start,
  input  logic             mem_wait,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_clear,
  output logic             idex_hold,
  output logic             idex_clear,
  output logic             exmem_hold,
  output logic             memwb_hold,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // The busy counter only ever holds values up to MD_LAT-1.
  localparam int             MD_W    = $clog2(MD_LAT);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT - 1);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  // All pipeline-register controls grouped so one default clears them all.
  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_clear;
    logic idex_hold;
    logic idex_clear;
    logic exmem_hold;
    logic memwb_hold;
  } pipe_ctrl_t;

  md_state_t       md_state;
  logic [MD_W-1:0] md_cnt;
  logic            md_busy_q;

  logic            lu;
  logic            mdh;
  logic            stall;
  logic            md_accept;
  pipe_ctrl_t      ctrl;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // $0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign lu = ex_mem_read && (ex_wr_reg != 5'd0) &&
              ((ex_wr_reg == id_rs) || (id_uses_rt && (ex_wr_reg == id_rt)));

  assign mdh   = id_md_op && md_busy_q;
  assign stall = lu || mdh;

  // A start is only taken when the EX instruction really advances: a freeze
  // keeps it in EX to be presented again, and a taken branch means the
  // mult/div op in EX is the branch itself, not a start.
  assign md_accept = ex_md_start && !mem_wait && !ex_br_taken;

  // ---------------------------------------------------------------------------
  // Pipeline control, priority encoded
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every field gets a default before the if-chain; a path that left
    // one unassigned would infer a latch.
    ctrl = '0;
    if (!rst_n) begin
      ctrl = '0;
    end else if (mem_wait) begin
      // Freeze: nothing moves, and a pending branch flush waits in EX.
      ctrl.pc_hold    = 1'b1;
      ctrl.ifid_hold  = 1'b1;
      ctrl.idex_hold  = 1'b1;
      ctrl.exmem_hold = 1'b1;
      ctrl.memwb_hold = 1'b1;
    end else if (ex_br_taken) begin
      // The wrong-path instructions in IF/ID and ID/EX are discarded; any
      // stall or jump they raised is moot.
      ctrl.ifid_clear = 1'b1;
      ctrl.idex_clear = 1'b1;
    end else if (stall) begin
      // Keep the ID instruction (jump included) and insert one bubble.
      ctrl.pc_hold    = 1'b1;
      ctrl.ifid_hold  = 1'b1;
      ctrl.idex_clear = 1'b1;
    end else if (id_jump) begin
      ctrl.ifid_clear = 1'b1;
    end
  end

  assign pc_hold    = ctrl.pc_hold;
  assign ifid_hold  = ctrl.ifid_hold;
  assign ifid_clear = ctrl.ifid_clear;
  assign idex_hold  = ctrl.idex_hold;
  assign idex_clear = ctrl.idex_clear;
  assign exmem_hold = ctrl.exmem_hold;
  assign memwb_hold = ctrl.memwb_hold;

  // ---------------------------------------------------------------------------
  // Mult/div busy tracking
  // ---------------------------------------------------------------------------
  // md_busy_q mirrors (md_cnt != 0) but is kept as its own flop so md_busy
  // comes straight from a register. The count runs through freezes because
  // the mult/div unit itself does not stop for memory.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      md_state  <= MD_IDLE;
      md_cnt    <= '0;
      md_busy_q <= 1'b0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (md_accept) begin
            md_state  <= MD_BUSY;
            md_cnt    <= MD_LOAD;
            md_busy_q <= 1'b1;
          end
        end
        MD_BUSY: begin
          // Further starts are ignored here; mdh keeps them from reaching EX.
          if (md_cnt == MD_W'(1)) begin
            md_state  <= MD_IDLE;
            md_cnt    <= '0;
            md_busy_q <= 1'b0;
          end else begin
            md_cnt <= md_cnt - MD_W'(1);
          end
        end
        default: begin
          md_state  <= MD_IDLE;
          md_cnt    <= '0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = md_busy_q;

  // ---------------------------------------------------------------------------
  // Stall-cycle performance counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (pc_hold && (stall_cycles != {CNT_W{1'b1}})) begin
      // Saturates at all-ones instead of wrapping back to zero.
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl with MD_LAT=4 and CNT_W=4. Inputs change
// on the falling clock edge and outputs are compared shortly afterwards, well
// away from the rising edge where state updates.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_md_op;
  logic             id_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_wr_reg;
  logic             ex_br_taken;
  logic             ex_md_start;
  logic             mem_wait;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_clear;
  logic             idex_hold;
  logic             idex_clear;
  logic             exmem_hold;
  logic             memwb_hold;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(
    .MD_LAT(MD_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_md_op    (id_md_op),
    .id_jump     (id_jump),
    .ex_mem_read (ex_mem_read),
    .ex_wr_reg   (ex_wr_reg),
    .ex_br_taken (ex_br_taken),
    .ex_md_start (ex_md_start),
    .mem_wait    (mem_wait),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .ifid_clear  (ifid_clear),
    .idex_hold   (idex_hold),
    .idex_clear  (idex_clear),
    .exmem_hold  (exmem_hold),
    .memwb_hold  (memwb_hold),
    .md_busy     (md_busy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control outputs packed MSB first:
  // {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear, exmem_hold, memwb_hold}
  logic [6:0] ctrl_vec;
  assign ctrl_vec = {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
                     exmem_hold, memwb_hold};

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       mem_read;
    logic [4:0] wr_reg;
    logic       br_taken;
    logic       mwait;
    logic [6:0] exp_ctrl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_idle();
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_uses_rt  = 1'b0;
    id_md_op    = 1'b0;
    id_jump     = 1'b0;
    ex_mem_read = 1'b0;
    ex_wr_reg   = 5'd0;
    ex_br_taken = 1'b0;
    ex_md_start = 1'b0;
    mem_wait    = 1'b0;
  endtask

  // Load-use on rs: load writing r8, ID reads r8.
  task automatic set_lu();
    set_idle();
    ex_mem_read = 1'b1;
    ex_wr_reg   = 5'd8;
    id_rs       = 5'd8;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Directed vectors with the mult/div unit idle.
    //            name           rs  rt  urt jmp mrd wr  br  mw   expected
    vecs[0]  = '{"idle",         0,  0,  0,  0,  0,  0,  0,  0,  7'b0000000};
    vecs[1]  = '{"lu_rs",        8,  0,  0,  0,  1,  8,  0,  0,  7'b1100100};
    vecs[2]  = '{"lu_r0",        0,  0,  0,  0,  1,  0,  0,  0,  7'b0000000};
    vecs[3]  = '{"rt_unused",    1,  9,  0,  0,  1,  9,  0,  0,  7'b0000000};
    vecs[4]  = '{"rt_used",      1,  9,  1,  0,  1,  9,  0,  0,  7'b1100100};
    vecs[5]  = '{"no_load",      8,  0,  0,  0,  0,  8,  0,  0,  7'b0000000};
    vecs[6]  = '{"reg_differ",   8,  3,  1,  0,  1,  7,  0,  0,  7'b0000000};
    vecs[7]  = '{"jump",         0,  0,  0,  1,  0,  0,  0,  0,  7'b0010000};
    vecs[8]  = '{"br_over_all",  8,  0,  0,  1,  1,  8,  1,  0,  7'b0010100};
    vecs[9]  = '{"lu_over_jump", 8,  0,  0,  1,  1,  8,  0,  0,  7'b1100100};
    vecs[10] = '{"wait_br",      0,  0,  0,  0,  0,  0,  1,  1,  7'b1101011};
    vecs[11] = '{"wait_lu_jmp",  8,  0,  0,  1,  1,  8,  0,  1,  7'b1101011};

    set_idle();
    rst_n = 1'b0;

    // Reset: outputs stay low even with a freeze and a hazard requested.
    @(negedge clk);
    set_lu();
    mem_wait = 1'b1;
    #1;
    check("reset_ctrl", 32'(ctrl_vec), 32'd0);
    @(negedge clk);
    check("reset_cnt", 32'(stall_cycles), 32'd0);
    check("reset_busy", 32'(md_busy), 32'd0);
    set_idle();
    rst_n = 1'b1;

    // Single-cycle load-use stall, then release.
    @(negedge clk);
    set_lu();
    #1;
    check("lu_stall", 32'(ctrl_vec), 32'(7'b1100100));
    @(negedge clk);
    set_idle();
    #1;
    check("lu_release", 32'(ctrl_vec), 32'd0);
    check("lu_cnt", 32'(stall_cycles), 32'd1);

    // Combinational priority table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_idle();
      id_rs       = vecs[i].rs;
      id_rt       = vecs[i].rt;
      id_uses_rt  = vecs[i].uses_rt;
      id_jump     = vecs[i].jump;
      ex_mem_read = vecs[i].mem_read;
      ex_wr_reg   = vecs[i].wr_reg;
      ex_br_taken = vecs[i].br_taken;
      mem_wait    = vecs[i].mwait;
      #1;
      check(vecs[i].name, 32'(ctrl_vec), 32'(vecs[i].exp_ctrl));
    end

    // Mult/div interlock: busy for MD_LAT-1 = 3 cycles, the waiting HI/LO op
    // is stalled for those 3 cycles (a jump in ID stays put) and proceeds on
    // the 4th.
    do_reset();
    @(negedge clk);
    ex_md_start = 1'b1;
    id_md_op    = 1'b1;
    #1;
    check("md_start_nostall", 32'(ctrl_vec), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_md_start = 1'b0;
      id_md_op    = 1'b1;
      id_jump     = 1'b1;
      #1;
      check($sformatf("md_busy_%0d", i), 32'(md_busy), 32'd1);
      check($sformatf("md_stall_%0d", i), 32'(ctrl_vec), 32'(7'b1100100));
    end
    @(negedge clk);
    id_jump = 1'b0;
    #1;
    check("md_done_busy", 32'(md_busy), 32'd0);
    check("md_done_ctrl", 32'(ctrl_vec), 32'd0);

    // A start offered during a freeze or alongside a taken branch is not taken.
    @(negedge clk);
    set_idle();
    ex_md_start = 1'b1;
    mem_wait    = 1'b1;
    @(negedge clk);
    check("md_reject_wait", 32'(md_busy), 32'd0);
    mem_wait    = 1'b0;
    ex_br_taken = 1'b1;
    @(negedge clk);
    check("md_reject_br", 32'(md_busy), 32'd0);
    set_idle();

    // Freeze with a pending taken branch; md count continues during the freeze.
    @(negedge clk);
    ex_md_start = 1'b1;
    @(negedge clk);
    ex_md_start = 1'b0;
    mem_wait    = 1'b1;
    ex_br_taken = 1'b1;
    #1;
    check("frz_ctrl", 32'(ctrl_vec), 32'(7'b1101011));
    check("frz_busy", 32'(md_busy), 32'd1);
    @(negedge clk);
    #1;
    check("frz_ctrl2", 32'(ctrl_vec), 32'(7'b1101011));
    @(negedge clk);
    mem_wait = 1'b0;
    #1;
    check("frz_flush", 32'(ctrl_vec), 32'(7'b0010100));
    check("frz_busy_last", 32'(md_busy), 32'd1);
    @(negedge clk);
    set_idle();
    #1;
    check("frz_md_counted", 32'(md_busy), 32'd0);

    // Reset in the middle of a busy period aborts it at the next edge.
    @(negedge clk);
    ex_md_start = 1'b1;
    @(negedge clk);
    ex_md_start = 1'b0;
    check("rst_pre_busy", 32'(md_busy), 32'd1);
    set_lu();
    rst_n = 1'b0;
    #1;
    check("rst_ctrl_low", 32'(ctrl_vec), 32'd0);
    @(negedge clk);
    check("rst_busy_abort", 32'(md_busy), 32'd0);
    check("rst_cnt_zero", 32'(stall_cycles), 32'd0);
    rst_n = 1'b1;

    // Saturation: 20 stall cycles on a 4-bit counter end at 15.
    set_lu();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 14) check("sat_at_15", 32'(stall_cycles), 32'd15);
    end
    set_idle();
    #1;
    check("sat_hold", 32'(stall_cycles), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives the hold/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold.
- Handles load-use stalls, multiply/divide busy interlock, branch/jump flushes and memory-wait freezes.
- Keeps a busy counter for the multi-cycle mult/div unit and a saturating stall-cycle counter.

Parameters:
- MD_LAT, 32: cycles the mult/div unit is busy after an accepted start (must be >= 2).
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt.
- id_md_op  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- id_jump  input  1  ID instruction is j/jal/jr (resolved in ID).
- ex_mem_read  input  1  EX instruction is a load.
- ex_wr_reg  input  5  destination register of EX instruction.
- ex_br_taken  input  1  branch in EX resolved taken.
- ex_md_start  input  1  EX instruction starts mult/div.
- mem_wait  input  1  data/instruction memory not ready; freeze pipeline.
- pc_hold  output  1  hold PC.
- ifid_hold  output  1  hold IF/ID.
- ifid_clear  output  1  clear IF/ID.
- idex_hold  output  1  hold ID/EX.
- idex_clear  output  1  clear ID/EX (bubble).
- exmem_hold  output  1  hold EX/MEM.
- memwb_hold  output  1  hold MEM/WB.
- md_busy  output  1  mult/div unit busy.
- stall_cycles  output  CNT_W  count of cycles with pc_hold=1.

Behaviour:
- Hold/clear outputs are combinational from the current inputs and registered state. The pipeline registers give clear priority over hold; this block still never asserts hold and clear together on one register.
- While rst_n=0, all outputs are 0, md_cnt=0 and stall_cycles=0. Reset mid-operation aborts any busy count immediately.
- Internal condition lu (load-use): ex_mem_read && ex_wr_reg!=0 && (ex_wr_reg==id_rs || (id_uses_rt && ex_wr_reg==id_rt)).
- Internal condition mdh (mult/div interlock): id_md_op && md_busy.
- stall = lu || mdh.
- Output priority per cycle, highest first:
  1. mem_wait=1: pc_hold, ifid_hold, idex_hold, exmem_hold and memwb_hold all =1; every clear =0. A taken branch stays in EX and is flushed once mem_wait drops.
  2. ex_br_taken=1: ifid_clear=1 and idex_clear=1; all holds =0. The branch wins over stall and jump.
  3. stall=1: pc_hold=1, ifid_hold=1, idex_clear=1, giving exactly one bubble per cycle the stall persists. A jump held in ID does not flush.
  4. id_jump=1: ifid_clear=1 only.
  5. Otherwise all outputs are 0.
- Mult/div FSM, states IDLE (md_cnt=0) and BUSY (md_cnt!=0). md_busy = (md_cnt!=0).
  - IDLE to BUSY: on ex_md_start && !mem_wait && !ex_br_taken, load md_cnt=MD_LAT-1.
  - In BUSY, md_cnt decrements each cycle, including while mem_wait=1, and returns to IDLE when it reaches 0.
  - ex_md_start while BUSY is ignored; mdh prevents it in normal flow.
  - md_busy is high for exactly MD_LAT-1 cycles after the accept edge. An ID md op that is stalled proceeds on the first cycle md_busy=0.
- stall_cycles increments by 1 on each posedge where pc_hold=1 (mem_wait or stall) and saturates at all-ones without wrapping.
- Register $0 never causes a load-use hazard.

Test Plan:
- Load-use: ex_mem_read=1, ex_wr_reg=8, id_rs=8 for 1 cycle -> pc_hold=ifid_hold=idex_clear=1 in that cycle, all 0 the next cycle, stall_cycles=1. Repeat with ex_wr_reg=0 -> no stall.
- rt gating: ex_wr_reg=9, id_rt=9, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Mult/div, MD_LAT=4: pulse ex_md_start -> md_busy=1 for 3 cycles. Holding id_md_op=1 -> 3 stall cycles with idex_clear=1; the 4th cycle has no stall.
- Branch priority: ex_br_taken=1 together with a load-use hazard and id_jump=1 -> ifid_clear=idex_clear=1, pc_hold=ifid_hold=0.
- Freeze: mem_wait=1 with ex_br_taken=1 -> all holds=1, all clears=0. Drop mem_wait -> flush occurs that cycle; md_cnt kept counting during the freeze.
- Reset and saturation: assert rst_n=0 while md_busy=1 -> next edge md_busy=0, stall_cycles=0. With CNT_W=4, 20 stall cycles -> stall_cycles=15.
